cpu_ctrl_fsm: RTL and testbench

- Instruction-sequencing controller for the simple RISC datapath.
- Latches one 16-bit instruction on a start handshake, decodes it, and steps the datapath through register read, operand load, ALU execute and writeback.
- Drives the ALU's 2-bit op select, the A/B/C/status load enables, register-file select/write, and the operand muxes.
- Sits directly upstream of the ALU and datapath; consumes nothing from them.

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/instr_dec.sv | 39 +++
 rtl/cpu_ctrl_fsm.sv | 118 +++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the RISC instruction controllers: state codes, opcode
// fields, regfile select codes, writeback source codes and ALU op codes.
package cpu_pkg;

    // Instruction width is fixed by the ISA.
    localparam int unsigned IW = 16;

    typedef logic [3:0] state_t;

    localparam state_t StWait    = 4'd0;
    localparam state_t StDecode  = 4'd1;
    localparam state_t StGetA    = 4'd2;
    localparam state_t StGetB    = 4'd3;
    localparam state_t StExec    = 4'd4;
    localparam state_t StCmpS    = 4'd5;
    localparam state_t StWrReg   = 4'd6;
    localparam state_t StWrImm   = 4'd7;
    localparam state_t StIllegal = 4'd8;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b100;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b001;

    localparam logic [1:0] VSEL_C    = 2'b00;
    localparam logic [1:0] VSEL_IMM8 = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

endpackage

// File: rtl/instr_dec.sv
// Combinational instruction decoder: field extraction, sign extension, ALU op
// selection and classification flags for the sequencing controller.
module instr_dec
    import cpu_pkg::*;
(
    input  logic [IW-1:0] ir,
    output logic [1:0]    shift,
    output logic [IW-1:0] sximm8,
    output logic [IW-1:0] sximm5,
    output logic [1:0]    alu_op,
    output logic          legal,
    output logic          is_mov_imm,
    output logic          is_mov_reg,
    output logic          is_cmp,
    output logic          is_mvn
);

    logic [2:0] opcode;
    logic [1:0] op;
    logic       is_alu;

    // Field extraction and classification of the latched instruction.
    always_comb begin
        opcode     = ir[15:13];
        op         = ir[12:11];
        shift      = ir[4:3];
        sximm8     = {{(IW-8){ir[7]}}, ir[7:0]};
        sximm5     = {{(IW-5){ir[4]}}, ir[4:0]};
        is_alu     = (opcode == OPC_ALU);
        is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
        is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
        is_cmp     = is_alu && (op == OP_CMP);
        is_mvn     = is_alu && (op == OP_MVN);
        legal      = is_alu || is_mov_imm || is_mov_reg;
        // MOV Rd,Rm passes B through an add with A forced to zero.
        alu_op     = is_alu ? op : ALU_ADD;
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Instruction-sequencing controller: latches an instruction on the start
// handshake and steps the datapath through read, load, execute and writeback.
module cpu_ctrl_fsm
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          s,
    input  logic [IW-1:0] instr,
    output logic          w,
    output logic          err,
    output logic [2:0]    nsel,
    output logic [1:0]    vsel,
    output logic          write,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          loads,
    output logic          asel,
    output logic          bsel,
    output logic [1:0]    ALUop,
    output logic [1:0]    shift,
    output logic [IW-1:0] sximm8,
    output logic [IW-1:0] sximm5
);

    state_t        state_q, state_d;
    logic [IW-1:0] ir_q;
    logic          legal, is_mov_imm, is_mov_reg, is_cmp, is_mvn;

    instr_dec u_dec (
        .ir         (ir_q),
        .shift      (shift),
        .sximm8     (sximm8),
        .sximm5     (sximm5),
        .alu_op     (ALUop),
        .legal      (legal),
        .is_mov_imm (is_mov_imm),
        .is_mov_reg (is_mov_reg),
        .is_cmp     (is_cmp),
        .is_mvn     (is_mvn)
    );

    // State register and instruction capture on the start handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StWait;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StWait && s) begin
                ir_q <= instr;
            end
        end
    end

    // Next-state sequencing; unknown codes recover to WAIT.
    always_comb begin
        state_d = StWait;
        case (state_q)
            StWait:    state_d = s ? StDecode : StWait;
            StDecode: begin
                if (!legal)                      state_d = StIllegal;
                else if (is_mov_imm)             state_d = StWrImm;
                else if (is_mov_reg || is_mvn)   state_d = StGetB;
                else                             state_d = StGetA;
            end
            StGetA:    state_d = StGetB;
            StGetB:    state_d = is_cmp ? StCmpS : StExec;
            StExec:    state_d = StWrReg;
            default:   state_d = StWait;
        endcase
    end

    // Moore control outputs; ALUop and immediates come straight from the decoder.
    always_comb begin
        w     = 1'b0;
        err   = 1'b0;
        nsel  = NSEL_NONE;
        vsel  = VSEL_C;
        write = 1'b0;
        loada = 1'b0;
        loadb = 1'b0;
        loadc = 1'b0;
        loads = 1'b0;
        asel  = 1'b0;
        bsel  = 1'b0;
        case (state_q)
            StWait:    w = 1'b1;
            StGetA: begin
                nsel  = NSEL_RN;
                loada = 1'b1;
            end
            StGetB: begin
                nsel  = NSEL_RM;
                loadb = 1'b1;
            end
            StExec: begin
                loadc = 1'b1;
                asel  = is_mov_reg || is_mvn;
            end
            StCmpS:    loads = 1'b1;
            StWrReg: begin
                nsel  = NSEL_RD;
                vsel  = VSEL_C;
                write = 1'b1;
            end
            StWrImm: begin
                nsel  = NSEL_RN;
                vsel  = VSEL_IMM8;
                write = 1'b1;
            end
            StIllegal: err = 1'b1;
            default:   w = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: a reference model pushes the expected
// per-cycle outputs of each instruction into a queue, popped as the DUT runs.
module tb_cpu_ctrl_fsm;

    typedef enum int {MWait, MDecode, MGetA, MGetB, MExec, MCmpS, MWrReg, MWrImm, MIllegal} mst_t;

    typedef struct packed {
        logic [17:0] ctrl;
        logic [15:0] imm8;
        logic [15:0] imm5;
    } exp_t;

    logic        clk, reset, s;
    logic [15:0] instr;
    logic        w, err, write, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  nsel;
    logic [1:0]  vsel, ALUop, shift;
    logic [15:0] sximm8, sximm5;

    exp_t        sb_q[$];
    logic [15:0] m_ir;
    int          checks = 0;
    int          errors = 0;

    cpu_ctrl_fsm dut (
        .clk    (clk),
        .reset  (reset),
        .s      (s),
        .instr  (instr),
        .w      (w),
        .err    (err),
        .nsel   (nsel),
        .vsel   (vsel),
        .write  (write),
        .loada  (loada),
        .loadb  (loadb),
        .loadc  (loadc),
        .loads  (loads),
        .asel   (asel),
        .bsel   (bsel),
        .ALUop  (ALUop),
        .shift  (shift),
        .sximm8 (sximm8),
        .sximm5 (sximm5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected control bundle {w,err,nsel,vsel,write,loada,loadb,loadc,loads,asel,bsel,ALUop,shift}.
    function automatic logic [17:0] model_ctrl(input mst_t st, input logic [15:0] ir);
        logic       mw, merr, mwr, mla, mlb, mlc, mls, mas;
        logic [2:0] mn;
        logic [1:0] mv, mop;
        mw = 0; merr = 0; mwr = 0; mla = 0; mlb = 0; mlc = 0; mls = 0; mas = 0;
        mn = 3'b000; mv = 2'b00;
        mop = (ir[15:13] == 3'b101) ? ir[12:11] : 2'b00;
        case (st)
            MWait:    mw = 1;
            MGetA:    begin mn = 3'b100; mla = 1; end
            MGetB:    begin mn = 3'b001; mlb = 1; end
            MExec:    begin mlc = 1; mas = (ir[15:13] == 3'b110) || (ir[12:11] == 2'b11); end
            MCmpS:    begin mls = 1; mop = 2'b01; end
            MWrReg:   begin mn = 3'b010; mwr = 1; end
            MWrImm:   begin mn = 3'b100; mv = 2'b10; mwr = 1; end
            MIllegal: merr = 1;
            default:  mw = 0;
        endcase
        return {mw, merr, mn, mv, mwr, mla, mlb, mlc, mls, mas, 1'b0, mop, ir[4:3]};
    endfunction

    task automatic push_state(input mst_t st);
        exp_t e;
        e.ctrl = model_ctrl(st, m_ir);
        e.imm8 = {{8{m_ir[7]}}, m_ir[7:0]};
        e.imm5 = {{11{m_ir[4]}}, m_ir[4:0]};
        sb_q.push_back(e);
    endtask

    task automatic push_trace(input logic [15:0] ins);
        logic [2:0] opc;
        logic [1:0] op;
        m_ir = ins;
        opc  = ins[15:13];
        op   = ins[12:11];
        push_state(MDecode);
        if (opc == 3'b110 && op == 2'b10) begin
            push_state(MWrImm);
        end else if ((opc == 3'b110 && op == 2'b00) || (opc == 3'b101 && op == 2'b11)) begin
            push_state(MGetB); push_state(MExec); push_state(MWrReg);
        end else if (opc == 3'b101) begin
            push_state(MGetA); push_state(MGetB);
            if (op == 2'b01) push_state(MCmpS);
            else begin push_state(MExec); push_state(MWrReg); end
        end else begin
            push_state(MIllegal);
        end
        push_state(MWait);
    endtask

    function automatic logic [17:0] dut_ctrl();
        return {w, err, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, ALUop, shift};
    endfunction

    // Pop one expected entry and compare against the DUT's present outputs.
    task automatic compare_head(input string tag);
        exp_t e;
        e = sb_q.pop_front();
        check({tag, ".ctrl"}, 32'(dut_ctrl()), 32'(e.ctrl));
        check({tag, ".sximm8"}, 32'(sximm8), 32'(e.imm8));
        check({tag, ".sximm5"}, 32'(sximm5), 32'(e.imm5));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            push_state(MWait);
            @(posedge clk); #1;
            compare_head("idle");
        end
    endtask

    // Start one instruction from WAIT; with hold_s, s stays high through it.
    task automatic run_instr(input string tag, input logic [15:0] ins, input bit hold_s);
        int  len, lat, wr, exp_wr;
        bit  wr_ins;
        check({tag, ".sb_empty"}, 32'(sb_q.size()), 32'd0);
        s     = 1'b1;
        instr = ins;
        push_trace(ins);
        len = sb_q.size();
        lat = 0;
        wr  = 0;
        for (int i = 1; i <= len; i++) begin
            @(posedge clk); #1;
            if (!hold_s) begin
                s     = 1'b0;
                instr = 16'($urandom);
            end
            if (write === 1'b1) wr++;
            if (w === 1'b1 && lat == 0) lat = i;
            compare_head(tag);
        end
        wr_ins = (ins[15:13] == 3'b110 && (ins[12:11] == 2'b10 || ins[12:11] == 2'b00)) ||
                 (ins[15:13] == 3'b101 && ins[12:11] != 2'b01);
        exp_wr = wr_ins ? 1 : 0;
        check({tag, ".latency"}, 32'(lat), 32'(len));
        check({tag, ".writes"}, 32'(wr), 32'(exp_wr));
    endtask

    initial begin
        reset = 1'b1;
        s     = 1'b0;
        instr = 16'h0000;
        m_ir  = 16'h0000;
        #2;
        push_state(MWait);
        compare_head("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);

        run_instr("mov_imm7", 16'hD007, 1'b0);
        idle(1);
        run_instr("mov_imm_m1", 16'hD3FF, 1'b0);
        run_instr("add", 16'hA148, 1'b0);
        run_instr("cmp", 16'hA900, 1'b0);
        run_instr("illegal", 16'hE000, 1'b0);
        run_instr("illegal_110_01", 16'hC800, 1'b0);
        run_instr("mov_reg", 16'hC0BA, 1'b0);
        run_instr("mvn", 16'hB8E1, 1'b0);
        run_instr("and", 16'hB0F3, 1'b0);
        idle(2);

        // Back-to-back: s held high, exactly one WAIT cycle between instructions.
        run_instr("b2b_add", 16'hA148, 1'b1);
        run_instr("b2b_imm", 16'hD180, 1'b1);
        run_instr("b2b_cmp", 16'hA900, 1'b0);
        idle(1);

        // Reset asserted mid-instruction during GET_B.
        s     = 1'b1;
        instr = 16'hA148;
        push_trace(16'hA148);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            s = 1'b0;
            compare_head("pre_reset");
        end
        sb_q.delete();
        #1 reset = 1'b1;
        #1;
        m_ir = 16'h0000;
        push_state(MWait);
        compare_head("midop_reset");
        @(posedge clk); #1;
        push_state(MWait);
        compare_head("held_reset");
        reset = 1'b0;
        idle(4);
        run_instr("post_reset_imm", 16'hD007, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
